// File: rtl/regsel_seq_if.sv
// Handshake and register-file bundle between the decode front end and regsel_seq.
// slave is the sequencer's view; master is the surrounding pipeline/register-file side.
interface regsel_seq_if #(
    parameter int DATA_W = 64
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instruction;
    logic              reg2loc;

    logic [4:0]        rf_addr;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        op_wsel;
    logic              op_movk;

    modport slave (
        input  instr_valid, instruction, reg2loc, rf_rdata,
               wb_valid, wb_addr, wb_data, op_ready,
        output instr_ready, rf_addr, rf_we, rf_wdata,
               wb_ready, op_valid, op_a, op_b, op_wsel, op_movk
    );

    modport master (
        output instr_valid, instruction, reg2loc, rf_rdata,
               wb_valid, wb_addr, wb_data, op_ready,
        input  instr_ready, rf_addr, rf_we, rf_wdata,
               wb_ready, op_valid, op_a, op_b, op_wsel, op_movk
    );
endinterface

// File: rtl/regsel_seq.sv
// Purpose: sequences two operand reads over one shared register-file port, with write-back and XZR handling.
// Latency: instruction accepted at edge 0 presents operands in cycle 4; one instruction per 5 cycles minimum.
// Backpressure: holds operands in OUT until op_ready; write-back stalls only during the two read cycles.
module regsel_seq #(
    parameter int DATA_W = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    regsel_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDB,
        CAPB,
        OUT
    } state_t;

    typedef struct packed {
        logic [4:0] sel1;
        logic [4:0] sel2;
        logic [4:0] wsel;
        logic       movk;
    } dec_t;

    localparam logic [10:0] MOVK_OPC = 11'b11110010100;
    localparam logic [4:0]  XZR      = 5'd31;

    state_t            state;
    dec_t              dec_q;
    dec_t              dec_d;
    logic              instr_ready_q;
    logic              wb_ready_q;
    logic              op_valid_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [4:0]        op_wsel_q;
    logic              op_movk_q;

    logic              instr_fire;
    logic              wb_fire;
    logic              wb_wr;
    logic              fwd_a;
    logic              fwd_b;
    logic [4:0]        rf_addr_d;
    logic              rf_we_d;
    logic [DATA_W-1:0] rf_wdata_d;
    logic              unused_instr_bits;

    assign instr_fire = bus.instr_valid && instr_ready_q;
    assign wb_fire    = bus.wb_valid && wb_ready_q;
    // A write-back to XZR completes the handshake but never touches the file.
    assign wb_wr      = wb_fire && (bus.wb_addr != XZR);
    assign fwd_a      = wb_wr && (bus.wb_addr == dec_q.sel1);
    assign fwd_b      = wb_wr && (bus.wb_addr == dec_q.sel2);

    assign unused_instr_bits = ^bus.instruction[15:10];

    always_comb begin
        dec_d      = '0;
        dec_d.movk = (bus.instruction[31:21] == MOVK_OPC);
        dec_d.sel1 = dec_d.movk ? bus.instruction[4:0] : bus.instruction[9:5];
        dec_d.sel2 = bus.reg2loc ? bus.instruction[4:0] : bus.instruction[20:16];
        dec_d.wsel = bus.instruction[4:0];
    end

    // Write-back owns the port whenever it is accepted; wb_ready is low in RDA/RDB so reads never collide.
    always_comb begin
        rf_addr_d  = '0;
        rf_we_d    = 1'b0;
        rf_wdata_d = '0;
        if (wb_wr) begin
            rf_addr_d  = bus.wb_addr;
            rf_we_d    = 1'b1;
            rf_wdata_d = bus.wb_data;
        end else if (state == RDA) begin
            rf_addr_d = dec_q.sel1;
        end else if (state == RDB) begin
            rf_addr_d = dec_q.sel2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            dec_q         <= '0;
            instr_ready_q <= 1'b0;
            wb_ready_q    <= 1'b0;
            op_valid_q    <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_wsel_q     <= '0;
            op_movk_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    instr_ready_q <= 1'b1;
                    wb_ready_q    <= 1'b1;
                    if (instr_fire) begin
                        state         <= RDA;
                        dec_q         <= dec_d;
                        instr_ready_q <= 1'b0;
                        wb_ready_q    <= 1'b0;
                    end
                end
                RDA: begin
                    state <= RDB;
                end
                RDB: begin
                    state      <= CAPB;
                    wb_ready_q <= 1'b1;
                    op_a_q     <= (dec_q.sel1 == XZR) ? '0 : bus.rf_rdata;
                end
                CAPB: begin
                    state      <= OUT;
                    op_valid_q <= 1'b1;
                    op_wsel_q  <= dec_q.wsel;
                    op_movk_q  <= dec_q.movk;
                    if (fwd_a) begin
                        op_a_q <= bus.wb_data;
                    end
                    if (fwd_b) begin
                        op_b_q <= bus.wb_data;
                    end else begin
                        op_b_q <= (dec_q.sel2 == XZR) ? '0 : bus.rf_rdata;
                    end
                end
                OUT: begin
                    // Operands are frozen here; late write-backs go only to the file.
                    if (bus.op_ready) begin
                        state         <= IDLE;
                        op_valid_q    <= 1'b0;
                        instr_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    instr_ready_q <= 1'b0;
                    wb_ready_q    <= 1'b0;
                    op_valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.wb_ready    = wb_ready_q;
    assign bus.op_valid    = op_valid_q;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.op_wsel     = op_wsel_q;
    assign bus.op_movk     = op_movk_q;
    assign bus.rf_addr     = rf_addr_d;
    assign bus.rf_we       = rf_we_d;
    assign bus.rf_wdata    = rf_wdata_d;

endmodule

// File: tb/tb_regsel_seq.sv
// Bench for regsel_seq: register-file model plus an architectural reference (operands = register state
// after all write-backs accepted up to the capture cycle, XZR reads as zero).
module tb_regsel_seq;
    localparam int DATA_W = 64;
    localparam int MAXC   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regsel_seq_if #(.DATA_W(DATA_W)) bus ();
    regsel_seq #(.DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Register file: synchronous read, data valid the cycle after the address.
    logic [DATA_W-1:0] rf_mem [32];
    logic              pl_en = 1'b0;
    logic [4:0]        pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) rf_mem[pl_addr] <= pl_data;
        else if (bus.rf_we) rf_mem[bus.rf_addr] <= bus.rf_wdata;
        else bus.rf_rdata <= rf_mem[bus.rf_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] ref_rf [32];
    logic [DATA_W-1:0] snap [32];
    int n_vec = 0;
    int n_err = 0;

    logic [4:0]        o_addr [MAXC];
    logic              o_we [MAXC];
    logic              o_wbrdy [MAXC];
    int                o_vld_cyc, o_out_cycles, o_wb_cyc, o_acc_time;
    logic [DATA_W-1:0] o_a, o_b, o_a_last, o_b_last;
    logic [4:0]        o_wsel;
    logic              o_movk;

    function automatic logic [4:0] sel1_of(input logic [31:0] ins);
        return (ins[31:21] == 11'b11110010100) ? ins[4:0] : ins[9:5];
    endfunction

    function automatic logic [4:0] sel2_of(input logic [31:0] ins, input logic r2l);
        return r2l ? ins[4:0] : ins[20:16];
    endfunction

    function automatic logic [DATA_W-1:0] reg_val(input logic [4:0] idx);
        return (idx == 5'd31) ? '0 : snap[idx];
    endfunction

    task automatic set_reg(input int idx, input logic [DATA_W-1:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = idx[4:0]; pl_data = v; ref_rf[idx] = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Drives one instruction (plus an optional write-back raised in cycle wb_cyc) and records outputs.
    task automatic issue(input logic [31:0] ins, input logic r2l, input int wb_cyc,
                         input logic [4:0] wa, input logic [DATA_W-1:0] wd, input int stall);
        int c, guard, outn;
        bit pend, done;
        for (int i = 0; i < MAXC; i++) begin o_addr[i] = 'x; o_we[i] = 1'bx; o_wbrdy[i] = 1'bx; end
        o_vld_cyc = -1; o_out_cycles = 0; o_wb_cyc = -1; o_acc_time = -1;
        o_a = 'x; o_b = 'x; o_a_last = 'x; o_b_last = 'x; o_wsel = 'x; o_movk = 1'bx;
        guard = 0;
        while (!bus.instr_ready && guard < 20) begin @(negedge clk); #1; guard++; end
        if (!bus.instr_ready) return;
        bus.instr_valid = 1'b1; bus.instruction = ins; bus.reg2loc = r2l;
        o_acc_time = cyc;
        pend = 1'b0; done = 1'b0; outn = 0; c = 0;
        while (!done && c < MAXC) begin
            if (c == wb_cyc) begin
                bus.wb_valid = 1'b1; bus.wb_addr = wa; bus.wb_data = wd; pend = 1'b1;
            end
            #1;
            o_addr[c] = bus.rf_addr; o_we[c] = bus.rf_we; o_wbrdy[c] = bus.wb_ready;
            if (pend && bus.wb_ready) begin
                o_wb_cyc = c;
                if (wa != 5'd31) ref_rf[wa] = wd;
            end
            if (c == 3) begin
                for (int i = 0; i < 32; i++) snap[i] = ref_rf[i];
            end
            if (bus.op_valid) begin
                if (o_vld_cyc < 0) begin
                    o_vld_cyc = c; o_a = bus.op_a; o_b = bus.op_b;
                    o_wsel = bus.op_wsel; o_movk = bus.op_movk;
                end
                o_a_last = bus.op_a; o_b_last = bus.op_b; o_out_cycles++;
                if (outn >= stall) begin bus.op_ready = 1'b1; done = 1'b1; end
                outn++;
            end
            @(negedge clk); #1;
            if (c == 0) bus.instr_valid = 1'b0;
            if (o_wb_cyc == c) begin bus.wb_valid = 1'b0; pend = 1'b0; end
            bus.op_ready = 1'b0;
            c++;
        end
    endtask

    task automatic test_reset();
        bus.instr_valid = 1'b1; bus.instruction = 32'h8B020023; bus.reg2loc = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 64'h55; bus.op_ready = 1'b0;
        #12;
        n_vec++; if (bus.instr_ready !== 1'b0) begin n_err++; $display("FAIL rst instr_ready got %b want 0", bus.instr_ready); end
        n_vec++; if (bus.wb_ready !== 1'b0) begin n_err++; $display("FAIL rst wb_ready got %b want 0", bus.wb_ready); end
        n_vec++; if (bus.op_valid !== 1'b0) begin n_err++; $display("FAIL rst op_valid got %b want 0", bus.op_valid); end
        n_vec++; if (bus.rf_we !== 1'b0 || bus.rf_addr !== 5'd0) begin n_err++; $display("FAIL rst rf got we=%b addr=%0d want 0/0", bus.rf_we, bus.rf_addr); end
        n_vec++; if (bus.op_a !== '0 || bus.op_b !== '0 || bus.op_wsel !== 5'd0 || bus.op_movk !== 1'b0) begin
            n_err++; $display("FAIL rst operands got a=%h b=%h w=%0d m=%b want 0", bus.op_a, bus.op_b, bus.op_wsel, bus.op_movk); end
        bus.instr_valid = 1'b0; bus.wb_valid = 1'b0;
        for (int i = 0; i < 32; i++) set_reg(i, {$urandom, $urandom});
        set_reg(1, 64'd5); set_reg(2, 64'd7);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (bus.instr_ready !== 1'b1 || bus.wb_ready !== 1'b1) begin
            n_err++; $display("FAIL post-rst ready got i=%b w=%b want 1/1", bus.instr_ready, bus.wb_ready); end
    endtask

    task automatic test_add();
        issue(32'h8B020023, 1'b0, -1, 5'd0, '0, 0);
        n_vec++; if (o_addr[1] !== 5'd1 || o_we[1] !== 1'b0) begin n_err++; $display("FAIL add rda got addr=%0d we=%b want 1/0", o_addr[1], o_we[1]); end
        n_vec++; if (o_addr[2] !== 5'd2 || o_we[2] !== 1'b0) begin n_err++; $display("FAIL add rdb got addr=%0d we=%b want 2/0", o_addr[2], o_we[2]); end
        n_vec++; if (o_addr[0] !== 5'd0 || o_addr[3] !== 5'd0) begin n_err++; $display("FAIL add idle addr got %0d/%0d want 0/0", o_addr[0], o_addr[3]); end
        n_vec++; if (o_vld_cyc !== 4) begin n_err++; $display("FAIL add latency got %0d want 4", o_vld_cyc); end
        n_vec++; if (o_a !== 64'd5 || o_b !== 64'd7) begin n_err++; $display("FAIL add ops got %h/%h want 5/7", o_a, o_b); end
        n_vec++; if (o_wsel !== 5'd3 || o_movk !== 1'b0) begin n_err++; $display("FAIL add wsel/movk got %0d/%b want 3/0", o_wsel, o_movk); end
        n_vec++; if ({o_wbrdy[0], o_wbrdy[1], o_wbrdy[2], o_wbrdy[3], o_wbrdy[4]} !== 5'b10011) begin
            n_err++; $display("FAIL add wb_ready pattern got %b%b%b%b%b want 10011", o_wbrdy[0], o_wbrdy[1], o_wbrdy[2], o_wbrdy[3], o_wbrdy[4]); end
    endtask

    task automatic test_movk();
        set_reg(4, 64'h1234); set_reg(13, 64'hDEAD);
        issue(32'hF29579A4, 1'b1, -1, 5'd0, '0, 0);
        n_vec++; if (o_addr[1] !== 5'd4) begin n_err++; $display("FAIL movk sel1 got %0d want 4", o_addr[1]); end
        n_vec++; if (o_a !== 64'h1234 || o_b !== 64'h1234) begin n_err++; $display("FAIL movk ops got %h/%h want 1234/1234", o_a, o_b); end
        n_vec++; if (o_movk !== 1'b1 || o_wsel !== 5'd4) begin n_err++; $display("FAIL movk flag got %b/%0d want 1/4", o_movk, o_wsel); end
    endtask

    task automatic test_xzr();
        set_reg(31, 64'hFFFF); set_reg(2, 64'h2222);
        issue(32'h8B0203E3, 1'b0, -1, 5'd0, '0, 0);
        n_vec++; if (o_addr[1] !== 5'd31) begin n_err++; $display("FAIL xzr rda addr got %0d want 31", o_addr[1]); end
        n_vec++; if (o_a !== '0 || o_b !== 64'h2222) begin n_err++; $display("FAIL xzr rn ops got %h/%h want 0/2222", o_a, o_b); end
        issue(32'h8B02003F, 1'b1, -1, 5'd0, '0, 0);
        n_vec++; if (o_a !== 64'd5 || o_b !== '0 || o_wsel !== 5'd31) begin
            n_err++; $display("FAIL xzr rm ops got %h/%h/%0d want 5/0/31", o_a, o_b, o_wsel); end
    endtask

    task automatic test_wb_forward();
        logic [DATA_W-1:0] wd;
        set_reg(2, 64'd7);
        issue(32'h8B020023, 1'b0, 1, 5'd2, 64'd9, 0);
        n_vec++; if (o_wbrdy[1] !== 1'b0 || o_wbrdy[2] !== 1'b0) begin n_err++; $display("FAIL fwd stall got %b%b want 00", o_wbrdy[1], o_wbrdy[2]); end
        n_vec++; if (o_wb_cyc !== 3 || o_addr[3] !== 5'd2 || o_we[3] !== 1'b1) begin
            n_err++; $display("FAIL fwd write got cyc=%0d addr=%0d we=%b want 3/2/1", o_wb_cyc, o_addr[3], o_we[3]); end
        n_vec++; if (o_a !== 64'd5 || o_b !== 64'd9) begin n_err++; $display("FAIL fwd ops got %h/%h want 5/9", o_a, o_b); end
        wd = {$urandom, $urandom};
        issue(32'h8B0600C0, 1'b0, 3, 5'd6, wd, 0);
        n_vec++; if (o_a !== wd || o_b !== wd) begin n_err++; $display("FAIL fwd both got %h/%h want %h", o_a, o_b, wd); end
        issue(32'h8B020023, 1'b0, 3, 5'd31, 64'hBAD, 0);
        n_vec++; if (o_we[3] !== 1'b0 || o_addr[3] !== 5'd0 || o_wb_cyc !== 3) begin
            n_err++; $display("FAIL wb31 got we=%b addr=%0d cyc=%0d want 0/0/3", o_we[3], o_addr[3], o_wb_cyc); end
        n_vec++; if (o_a !== 64'd5 || o_b !== 64'd9) begin n_err++; $display("FAIL wb31 ops got %h/%h want 5/9", o_a, o_b); end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] wd;
        wd = {$urandom, $urandom};
        issue(32'h8B020023, 1'b0, 4, 5'd1, wd, 3);
        n_vec++; if (o_out_cycles !== 4) begin n_err++; $display("FAIL stall op_valid cycles got %0d want 4", o_out_cycles); end
        n_vec++; if (o_a !== 64'd5 || o_a_last !== 64'd5 || o_b_last !== 64'd9) begin
            n_err++; $display("FAIL stall hold got %h/%h/%h want 5/5/9", o_a, o_a_last, o_b_last); end
        n_vec++; if (o_wb_cyc !== 4) begin n_err++; $display("FAIL stall wb accept got %0d want 4", o_wb_cyc); end
        issue(32'h8B020023, 1'b0, -1, 5'd0, '0, 0);
        n_vec++; if (o_a !== wd) begin n_err++; $display("FAIL stall later read got %h want %h", o_a, wd); end
    endtask

    task automatic test_idle_wb();
        logic [DATA_W-1:0] wd;
        wd = {$urandom, $urandom};
        issue(32'h8B020023, 1'b0, 0, 5'd1, wd, 0);
        n_vec++; if (o_wb_cyc !== 0 || o_we[0] !== 1'b1 || o_addr[0] !== 5'd1) begin
            n_err++; $display("FAIL idle wb got cyc=%0d we=%b addr=%0d want 0/1/1", o_wb_cyc, o_we[0], o_addr[0]); end
        n_vec++; if (o_a !== wd) begin n_err++; $display("FAIL idle wb op_a got %h want %h", o_a, wd); end
    endtask

    task automatic test_back_to_back();
        int t0;
        issue(32'h8B020023, 1'b0, -1, 5'd0, '0, 0);
        t0 = o_acc_time;
        issue(32'h8B0600C0, 1'b0, -1, 5'd0, '0, 0);
        n_vec++; if (o_acc_time - t0 !== 5) begin n_err++; $display("FAIL b2b spacing got %0d want 5", o_acc_time - t0); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic r2l;
        logic [4:0] wa, s1, s2;
        logic [DATA_W-1:0] wd;
        int wcyc, stall, pick;
        for (int i = 0; i < 31; i++) set_reg(i, {$urandom, $urandom});
        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) == 0) ins[31:21] = 11'b11110010100;
            r2l = 1'($urandom_range(0, 1));
            s1 = sel1_of(ins); s2 = sel2_of(ins, r2l);
            pick = int'($urandom_range(0, 3));
            wa = (pick == 0) ? s1 : (pick == 1) ? s2 : 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            wcyc = int'($urandom_range(0, 5)) - 1;
            stall = int'($urandom_range(0, 2));
            issue(ins, r2l, wcyc, wa, wd, stall);
            n_vec++; if (o_vld_cyc !== 4) begin n_err++; $display("FAIL rnd%0d latency got %0d want 4", n, o_vld_cyc); end
            n_vec++; if (o_a !== reg_val(s1)) begin n_err++; $display("FAIL rnd%0d op_a got %h want %h", n, o_a, reg_val(s1)); end
            n_vec++; if (o_b !== reg_val(s2)) begin n_err++; $display("FAIL rnd%0d op_b got %h want %h", n, o_b, reg_val(s2)); end
            n_vec++; if (o_wsel !== ins[4:0] || o_movk !== (ins[31:21] == 11'b11110010100)) begin
                n_err++; $display("FAIL rnd%0d wsel/movk got %0d/%b want %0d", n, o_wsel, o_movk, ins[4:0]); end
            n_vec++; if (o_a_last !== o_a || o_out_cycles !== stall + 1) begin
                n_err++; $display("FAIL rnd%0d hold got a_last=%h cycles=%0d want %h/%0d", n, o_a_last, o_out_cycles, o_a, stall + 1); end
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        bit seen;
        guard = 0;
        while (!bus.instr_ready && guard < 20) begin @(negedge clk); #1; guard++; end
        bus.instr_valid = 1'b1; bus.instruction = 32'h8B020023; bus.reg2loc = 1'b0;
        @(negedge clk); #1; bus.instr_valid = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (bus.rf_addr !== 5'd2) begin n_err++; $display("FAIL midrst rdb addr got %0d want 2", bus.rf_addr); end
        rst_n = 1'b0; #1;
        n_vec++; if (bus.instr_ready !== 1'b0 || bus.wb_ready !== 1'b0 || bus.op_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst flags got i=%b w=%b v=%b want 0", bus.instr_ready, bus.wb_ready, bus.op_valid); end
        n_vec++; if (bus.op_a !== '0 || bus.op_b !== '0 || bus.op_wsel !== 5'd0 || bus.op_movk !== 1'b0) begin
            n_err++; $display("FAIL midrst ops got a=%h b=%h w=%0d m=%b want 0", bus.op_a, bus.op_b, bus.op_wsel, bus.op_movk); end
        n_vec++; if (bus.rf_addr !== 5'd0 || bus.rf_we !== 1'b0) begin n_err++; $display("FAIL midrst rf got %0d/%b want 0/0", bus.rf_addr, bus.rf_we); end
        @(negedge clk); #1; rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); #1; if (bus.op_valid) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst op_valid seen got %b want 0", seen); end
        n_vec++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL midrst idle ready got %b want 1", bus.instr_ready); end
    endtask

    initial begin
        bus.instr_valid = 1'b0; bus.instruction = '0; bus.reg2loc = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.op_ready = 1'b0;
        test_reset();
        test_add();
        test_movk();
        test_xzr();
        test_wb_forward();
        test_stall();
        test_idle_wb();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
